// File: rtl/cdc_handshake_tx.sv
// Source half of the toggle-handshake CDC: registers a word, toggles a request,
// and waits for the destination's toggle acknowledge through a local synchronizer.
module cdc_handshake_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int SYNC_DEPTH     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  async_rst_n,
  input  logic                  clk_en,
  input  logic                  src_valid_i,
  input  logic [DATA_WIDTH-1:0] src_data_i,
  output logic                  src_ready_o,
  output logic                  done_o,
  output logic                  xfer_req_o,
  output logic [DATA_WIDTH-1:0] xfer_data_o,
  input  logic                  xfer_ack_i,
  output logic                  timeout_o,
  output logic                  proto_err_o,
  input  logic                  err_clear_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic {
    IDLE,
    WAIT_ACK
  } state_t;

  state_t                  state_q;
  logic [SYNC_DEPTH-1:0]   sync_q;
  logic                    ack_s;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_next;
  logic                    req_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    done_q;
  logic                    timeout_q;
  logic                    proto_q;
  logic                    to_hit;
  logic                    pe_hit;

  // Acknowledge synchronizer runs every edge, independent of clk_en.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], xfer_ack_i};
    end
  end

  assign ack_s = sync_q[SYNC_DEPTH-1];

  always_comb begin
    cnt_next = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    to_hit   = TIMEOUT_EN && (state_q == WAIT_ACK) && clk_en && (cnt_next == CNT_MAX);
    pe_hit   = (state_q == IDLE) && (ack_s != req_q);
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      proto_q   <= 1'b0;
    end else begin
      if (clk_en) begin
        done_q <= 1'b0;
        case (state_q)
          IDLE: begin
            if (src_valid_i) begin
              data_q  <= src_data_i;
              req_q   <= ~req_q;
              cnt_q   <= '0;
              state_q <= WAIT_ACK;
            end
          end
          WAIT_ACK: begin
            cnt_q <= cnt_next;
            if (ack_s == req_q) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
      // Sticky flags: a set in the same cycle as a clear takes priority.
      timeout_q <= to_hit | (timeout_q & ~err_clear_i);
      proto_q   <= pe_hit | (proto_q & ~err_clear_i);
    end
  end

  assign src_ready_o = (state_q == IDLE) & async_rst_n;
  assign done_o      = done_q;
  assign xfer_req_o  = req_q;
  assign xfer_data_o = data_q;
  assign timeout_o   = timeout_q;
  assign proto_err_o = proto_q;

endmodule
